// File: rtl/muller_c_hs_driver.sv
// -----------------------------------------------------------------------------
// muller_c_hs_driver
//   Clocked stimulus/checker that runs a Muller C-element through four-phase
//   handshakes. It drives the element inputs c_a/c_b and watches the element
//   output through a SYNC_STAGES-deep synchronizer. The element must follow
//   its inputs only when both inputs agree, and must hold otherwise. A run
//   counts completed handshakes. The first violation or timeout is latched
//   into error/fail_state.
//
// Ports
//   clock        in   1      system clock
//   reset_n      in   1      asynchronous active-low reset
//   start        in   1      1-cycle pulse; starts a run when idle or faulted
//   mode         in   2      00 A-then-B, 01 B-then-A, 10 simultaneous, 11 = 00
//   n_hs         in   8      handshakes per run (0 = finish with none)
//   c_out_async  in   1      C-element output, asynchronous to clock
//   c_a, c_b     out  1      C-element inputs (registered, glitch-free)
//   busy         out  1      run in progress
//   done         out  1      1-cycle pulse on successful completion
//   error        out  1      sticky fault flag
//   fail_state   out  3      state code in which the fault was detected
//   hs_count     out  CNT_W  handshakes completed in the current/last run
// -----------------------------------------------------------------------------
module muller_c_hs_driver #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYC    = 4,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [7:0]       n_hs,
    input  logic             c_out_async,
    output logic             c_a,
    output logic             c_b,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [2:0]       fail_state,
    output logic [CNT_W-1:0] hs_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SET1    = 3'd1,
        S_SET2    = 3'd2,
        S_WAIT_HI = 3'd3,
        S_CLR1    = 3'd4,
        S_CLR2    = 3'd5,
        S_WAIT_LO = 3'd6,
        S_FAULT   = 3'd7
    } state_t;

    localparam logic [7:0] HOLD_LAST    = 8'(HOLD_CYC - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t                 state, state_next;
    logic [7:0]             cyc_cnt;
    logic [1:0]             mode_q, mode_next;
    logic [7:0]             n_hs_q, n_hs_next;
    logic [CNT_W-1:0]       hs_next;
    logic [CNT_W:0]         hs_plus;
    logic                   done_next, error_next, busy_next;
    logic                   c_a_next, c_b_next;
    logic [2:0]             fail_next;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   c_sync, simul, hold_over, timeout_hit;

    // The FSM looks only at the last synchronizer stage.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the values from before the edge, whatever the statement order.
        if (!reset_n) sync_q <= '0;
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], c_out_async};
    end

    assign c_sync      = sync_q[SYNC_STAGES-1];
    assign simul       = (mode_q == 2'b10);
    assign hold_over   = (cyc_cnt == HOLD_LAST);
    assign timeout_hit = (cyc_cnt == TIMEOUT_LAST);
    // One bit wider than hs_count, so the completion compare is exact even at saturation.
    assign hs_plus     = {1'b0, hs_count} + (CNT_W+1)'(1);

    // Next-state logic and run bookkeeping.
    always_comb begin
        // NOTE: every variable gets a default first, so no path through the
        // block leaves one unassigned and no latch is inferred.
        state_next = state;
        mode_next  = mode_q;
        n_hs_next  = n_hs_q;
        hs_next    = hs_count;
        done_next  = 1'b0;
        error_next = error;
        fail_next  = fail_state;

        unique case (state)
            S_IDLE, S_FAULT: begin
                if (start) begin
                    mode_next  = mode;
                    n_hs_next  = n_hs;
                    hs_next    = '0;
                    error_next = 1'b0;
                    fail_next  = 3'd0;
                    if (n_hs == 8'd0) begin
                        done_next  = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_SET1;
                    end
                end
            end
            S_SET1: begin
                // Only one input is up (or both, in simultaneous mode), so the output must still be low.
                if (c_sync)         state_next = S_FAULT;
                else if (simul)     state_next = S_WAIT_HI;
                else if (hold_over) state_next = S_SET2;
            end
            S_SET2:                 state_next = S_WAIT_HI;
            S_WAIT_HI: begin
                // An arrival wins over a timeout in the same cycle.
                if (c_sync)           state_next = S_CLR1;
                else if (timeout_hit) state_next = S_FAULT;
            end
            S_CLR1: begin
                // The inputs now disagree, so the output must hold high.
                if (!c_sync)        state_next = S_FAULT;
                else if (simul)     state_next = S_WAIT_LO;
                else if (hold_over) state_next = S_CLR2;
            end
            S_CLR2:                 state_next = S_WAIT_LO;
            S_WAIT_LO: begin
                if (!c_sync) begin
                    hs_next = (&hs_count) ? hs_count : hs_plus[CNT_W-1:0];
                    if (hs_plus == (CNT_W+1)'(n_hs_q)) begin
                        done_next  = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_SET1;
                    end
                end else if (timeout_hit) begin
                    state_next = S_FAULT;
                end
            end
        endcase

        // Record where the fault was detected, on the transition into FAULT only.
        if (state_next == S_FAULT && state != S_FAULT) begin
            error_next = 1'b1;
            fail_next  = state;
        end
    end

    // The input levels are a pure function of the state being entered.
    // Registering them means they change only on state entry.
    always_comb begin
        c_a_next = 1'b0;
        c_b_next = 1'b0;
        case (state_next)
            S_SET1: begin
                c_a_next = (mode_next != 2'b01);
                c_b_next = (mode_next == 2'b01) || (mode_next == 2'b10);
            end
            S_SET2, S_WAIT_HI: begin
                c_a_next = 1'b1;
                c_b_next = 1'b1;
            end
            S_CLR1: begin
                // The first input has dropped. The other input stays high (both drop in mode 10).
                c_a_next = (mode_next == 2'b01);
                c_b_next = (mode_next[1] == mode_next[0]);
            end
            default: ;
        endcase
        busy_next = (state_next != S_IDLE) && (state_next != S_FAULT);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cyc_cnt    <= 8'd0;
            mode_q     <= 2'b00;
            n_hs_q     <= 8'd0;
            hs_count   <= '0;
            c_a        <= 1'b0;
            c_b        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            fail_state <= 3'd0;
        end else begin
            state      <= state_next;
            // Restarts on every state entry. It saturates so that it cannot wrap in IDLE or FAULT.
            if (state_next != state)  cyc_cnt <= 8'd0;
            else if (cyc_cnt != 8'hFF) cyc_cnt <= cyc_cnt + 8'd1;
            mode_q     <= mode_next;
            n_hs_q     <= n_hs_next;
            hs_count   <= hs_next;
            c_a        <= c_a_next;
            c_b        <= c_b_next;
            busy       <= busy_next;
            done       <= done_next;
            error      <= error_next;
            fail_state <= fail_next;
        end
    end

endmodule

// File: tb/tb_muller_c_hs_driver.sv
// -----------------------------------------------------------------------------
// tb_muller_c_hs_driver
//   Bench for muller_c_hs_driver. A behavioural element (C-element, stuck-at
//   0/1, or AND gate) with a 3 time-unit propagation delay closes the loop.
//   Each run is summarised as edge counts and first-edge times. The summary is
//   compared against hand-written table entries and against a run-level
//   reference model for random runs.
// -----------------------------------------------------------------------------
module tb_muller_c_hs_driver;

    localparam int HOLD_CYC    = 4;
    localparam int TIMEOUT_CYC = 64;
    localparam int CNT_W       = 16;
    localparam int RUN_BUDGET  = 1500;

    typedef enum int {K_GOOD, K_STUCK0, K_STUCK1, K_AND} kind_t;

    typedef struct {
        logic [1:0] mode;
        int         n;
        kind_t      kind;
        int         restart_at;   // cycle of an extra start pulse during the run, 0 = none
        int         exp_err;
        int         exp_fs;
        int         exp_hs;
        int         exp_dones;
    } vec_t;

    typedef struct {
        int err, fs, hs, dones, a_rises, b_rises;
        int t_a_rise, t_b_rise, t_a_fall, t_b_fall, t_err;
        int busy_c1, done_c1, busy_end, ab_end, timed_out;
    } res_t;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             start;
    logic [1:0]       mode_in;
    logic [7:0]       n_hs_in;
    logic             c_out_async;
    logic             c_a, c_b, busy, done, error;
    logic [2:0]       fail_state;
    logic [CNT_W-1:0] hs_count;

    int n_checks = 0;
    int n_errors = 0;

    muller_c_hs_driver #(
        .SYNC_STAGES(2), .HOLD_CYC(HOLD_CYC), .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .mode(mode_in), .n_hs(n_hs_in),
        .c_out_async(c_out_async), .c_a(c_a), .c_b(c_b), .busy(busy), .done(done),
        .error(error), .fail_state(fail_state), .hs_count(hs_count)
    );

    always #5 clock = ~clock;

    // Element model: a C-element follows its inputs only when they agree.
    kind_t model_kind = K_GOOD;
    logic  c_model    = 1'b0;
    always @(c_a or c_b or model_kind) begin
        case (model_kind)
            K_GOOD:   if (c_a == c_b) c_model = c_a;
            K_STUCK0: c_model = 1'b0;
            K_STUCK1: c_model = 1'b1;
            default:  c_model = c_a & c_b;
        endcase
    end
    assign #3 c_out_async = c_model;

    task automatic check(input string name, input logic signed [31:0] actual,
                         input logic signed [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference model at run level. It gives the outcome of a whole run from
    // the element kind alone.
    function automatic vec_t predict(input logic [1:0] m, input int n, input kind_t k);
        vec_t v;
        int   fs;
        v.mode = m; v.n = n; v.kind = k; v.restart_at = 0;
        fs = 0;
        if (n != 0) begin
            if (k == K_STUCK1)                  fs = 1;  // output high while one input is up
            else if (k == K_STUCK0)             fs = 3;  // output never rises
            else if (k == K_AND && m != 2'b10)  fs = 4;  // output drops with one input
        end
        v.exp_err   = (fs != 0) ? 1 : 0;
        v.exp_fs    = fs;
        v.exp_hs    = (fs != 0) ? 0 : n;
        v.exp_dones = (fs != 0) ? 0 : 1;
        return v;
    endfunction

    task automatic run(input vec_t v, output res_t r);
        int   cyc, tail;
        bit   fin;
        logic pa, pb;
        r = '{default: 0};
        r.t_a_rise = -1; r.t_b_rise = -1; r.t_a_fall = -1; r.t_b_fall = -1; r.t_err = -1;
        model_kind = v.kind;
        repeat (4) @(negedge clock);
        mode_in = v.mode; n_hs_in = 8'(v.n); start = 1'b1;
        pa = c_a; pb = c_b;
        cyc = 0; tail = 0; fin = 1'b0;
        while (cyc < RUN_BUDGET && tail < 4) begin
            @(negedge clock);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0; r.busy_c1 = busy; r.done_c1 = done;
            end
            if (v.restart_at != 0 && cyc == v.restart_at) begin
                start = 1'b1; n_hs_in = 8'd0; mode_in = 2'b10;
            end else if (v.restart_at != 0 && cyc == v.restart_at + 1) begin
                start = 1'b0;
            end
            if (done) r.dones++;
            if (c_a && !pa) begin r.a_rises++; if (r.t_a_rise < 0) r.t_a_rise = cyc; end
            if (c_b && !pb) begin r.b_rises++; if (r.t_b_rise < 0) r.t_b_rise = cyc; end
            if (!c_a && pa && r.t_a_fall < 0) r.t_a_fall = cyc;
            if (!c_b && pb && r.t_b_fall < 0) r.t_b_fall = cyc;
            if (error && r.t_err < 0) r.t_err = cyc;
            pa = c_a; pb = c_b;
            if (done || error) fin = 1'b1;
            if (fin) tail++;
        end
        r.timed_out = fin ? 0 : 1;
        r.err = int'(error); r.fs = int'(fail_state); r.hs = int'(hs_count);
        r.busy_end = int'(busy); r.ab_end = int'({c_a, c_b});
    endtask

    task automatic verify(input string tag, input vec_t v, input res_t r);
        int gap, last_rise;
        gap = (v.mode == 2'b01) ? -HOLD_CYC : (v.mode == 2'b10) ? 0 : HOLD_CYC;
        check({tag, ".finished"},   r.timed_out, 0);
        check({tag, ".error"},      r.err,       v.exp_err);
        check({tag, ".fail_state"}, r.fs,        v.exp_fs);
        check({tag, ".hs_count"},   r.hs,        v.exp_hs);
        check({tag, ".done_count"}, r.dones,     v.exp_dones);
        check({tag, ".busy_end"},   r.busy_end,  0);
        check({tag, ".ab_end"},     r.ab_end,    0);
        if (v.n == 0) begin
            check({tag, ".done_next_cycle"}, r.done_c1, 1);
            check({tag, ".no_input_rise"},   r.a_rises + r.b_rises, 0);
        end else begin
            check({tag, ".busy_after_start"}, r.busy_c1, 1);
            if (v.exp_err == 0) begin
                check({tag, ".a_rises"},  r.a_rises, v.n);
                check({tag, ".b_rises"},  r.b_rises, v.n);
                check({tag, ".rise_gap"}, r.t_b_rise - r.t_a_rise, gap);
                check({tag, ".fall_gap"}, r.t_b_fall - r.t_a_fall, gap);
            end else if (v.exp_fs == 3) begin
                last_rise = (r.t_a_rise > r.t_b_rise) ? r.t_a_rise : r.t_b_rise;
                check({tag, ".timeout_latency"}, r.t_err - last_rise, TIMEOUT_CYC + 1);
            end
        end
    endtask

    vec_t vecs[11];
    vec_t v;
    res_t r;

    initial begin
        int cyc, kr;
        kind_t k;
        // mode, n, kind, restart_at, err, fail_state, hs, dones
        vecs[0]  = '{2'd0, 3, K_GOOD,   0, 0, 0, 3, 1};
        vecs[1]  = '{2'd2, 5, K_GOOD,   0, 0, 0, 5, 1};
        vecs[2]  = '{2'd0, 2, K_STUCK0, 0, 1, 3, 0, 0};
        vecs[3]  = '{2'd1, 2, K_AND,    0, 1, 4, 0, 0};
        vecs[4]  = '{2'd0, 0, K_GOOD,   0, 0, 0, 0, 1};
        vecs[5]  = '{2'd3, 2, K_GOOD,   0, 0, 0, 2, 1};
        vecs[6]  = '{2'd1, 4, K_GOOD,   0, 0, 0, 4, 1};
        vecs[7]  = '{2'd2, 2, K_AND,    0, 0, 0, 2, 1};
        vecs[8]  = '{2'd2, 1, K_STUCK0, 0, 1, 3, 0, 0};
        vecs[9]  = '{2'd0, 3, K_STUCK1, 0, 1, 1, 0, 0};
        vecs[10] = '{2'd0, 4, K_GOOD,  10, 0, 0, 4, 1};

        reset_n = 1'b0; start = 1'b0; mode_in = 2'b00; n_hs_in = 8'd0;
        repeat (3) @(negedge clock);
        check("reset.outputs", {c_a, c_b, busy, done, error, fail_state}, 0);
        check("reset.hs_count", hs_count, 0);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            run(vecs[i], r);
            verify($sformatf("vec%0d", i), vecs[i], r);
        end

        // Reset asserted mid-WAIT_HI in a 10-handshake run.
        model_kind = K_GOOD;
        repeat (3) @(negedge clock);
        mode_in = 2'b00; n_hs_in = 8'd10; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 0;
        while (!(hs_count == 2 && c_a && c_b) && cyc < RUN_BUDGET) begin
            @(negedge clock);
            cyc++;
        end
        check("midrst.reached", (cyc < RUN_BUDGET) ? 1 : 0, 1);
        @(negedge clock);   // SET2 -> WAIT_HI
        check("midrst.busy_before", busy, 1);
        check("midrst.hs_before", hs_count, 2);
        #2 reset_n = 1'b0;
        #1;
        check("midrst.outputs_async", {c_a, c_b, busy, done, error, fail_state}, 0);
        check("midrst.hs_async", hs_count, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        v = predict(2'b00, 3, K_GOOD);
        run(v, r);
        verify("after_rst", v, r);

        // Random runs against the reference model.
        for (int i = 0; i < 16; i++) begin
            kr = $urandom_range(0, 9);
            k  = (kr <= 5) ? K_GOOD : (kr == 6) ? K_STUCK0 : (kr == 7) ? K_STUCK1 : K_AND;
            v  = predict(2'($urandom_range(0, 3)), $urandom_range(0, 6), k);
            run(v, r);
            verify($sformatf("rnd%0d", i), v, r);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
